// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default byte width and the
// FIFO entry layout (tlast kept alongside the data byte).
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;

   typedef struct packed {
      logic                       tlast;
      logic [UART_DATA_WIDTH-1:0] tdata;
   } uart_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Plain storage array for the TX FIFO: one clocked write port and one
// asynchronous read port. Contents are intentionally not reset.
module uart_fifo_mem #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through AXIS FIFO in front of the UART transmitter.
// Define UART_TX_FIFO_PKT_MODE_EN to hold bytes back until a whole packet is stored.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [DATA_WIDTH-1:0]    slv_axis_tdata_i,
   input  logic                     slv_axis_tvalid_i,
   input  logic                     slv_axis_tlast_i,
   output logic                     slv_axis_tready_o,
   output logic [DATA_WIDTH-1:0]    mst_axis_tdata_o,
   output logic                     mst_axis_tvalid_o,
   output logic                     mst_axis_tlast_o,
   input  logic                     mst_axis_tready_i,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   typedef struct packed {
      logic                  tlast;
      logic [DATA_WIDTH-1:0] tdata;
   } entry_t;

   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic        push;
   logic        pop;
   entry_t      wr_entry;
   entry_t      rd_entry;

   assign wr_entry = '{tlast: slv_axis_tlast_i, tdata: slv_axis_tdata_i};

   uart_fifo_mem #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (push),
      .waddr_i (wr_ptr[PW-1:0]),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr[PW-1:0]),
      .rdata_o (rd_entry)
   );

   // Flags come only from the registered pointers; the extra MSB tells full from empty.
   assign empty_o           = (wr_ptr == rd_ptr);
   assign full_o            = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
   assign level_o           = wr_ptr - rd_ptr;
   assign slv_axis_tready_o = !full_o;

   assign push = slv_axis_tvalid_i && slv_axis_tready_o;
   assign pop  = mst_axis_tvalid_o && mst_axis_tready_i;

`ifdef UART_TX_FIFO_PKT_MODE_EN
   logic [PW:0] pkt_cnt;
   logic        push_last;
   logic        pop_last;

   assign push_last = push && slv_axis_tlast_i;
   assign pop_last  = pop && rd_entry.tlast;

   // Releasing on full avoids deadlock when a packet is longer than the FIFO.
   assign mst_axis_tvalid_o = !empty_o && ((pkt_cnt != '0) || full_o);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) begin
         pkt_cnt <= '0;
      end else if (push_last && !pop_last) begin
         pkt_cnt <= pkt_cnt + PTR_ONE;
      end else if (pop_last && !push_last) begin
         pkt_cnt <= pkt_cnt - PTR_ONE;
      end
   end
`else
   assign mst_axis_tvalid_o = !empty_o;
`endif

   assign mst_axis_tdata_o = mst_axis_tvalid_o ? rd_entry.tdata : '0;
   assign mst_axis_tlast_o = mst_axis_tvalid_o && rd_entry.tlast;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a queue-based model
// (honours UART_TX_FIFO_PKT_MODE_EN for the packet-hold rule).
module tb_uart_tx_fifo;
   import uart_pkg::*;

   localparam int DW    = UART_DATA_WIDTH;
   localparam int DEPTH = 16;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic [DW-1:0] slv_axis_tdata_i = '0;
   logic          slv_axis_tvalid_i = 1'b0;
   logic          slv_axis_tlast_i = 1'b0;
   logic          slv_axis_tready_o;
   logic [DW-1:0] mst_axis_tdata_o;
   logic          mst_axis_tvalid_o;
   logic          mst_axis_tlast_o;
   logic          mst_axis_tready_i = 1'b0;
   logic          flush_i = 1'b0;
   logic [$clog2(DEPTH):0] level_o;
   logic          empty_o;
   logic          full_o;

   int checks   = 0;
   int failures = 0;

   uart_entry_t model_q[$];

   uart_tx_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .slv_axis_tdata_i  (slv_axis_tdata_i),
      .slv_axis_tvalid_i (slv_axis_tvalid_i),
      .slv_axis_tlast_i  (slv_axis_tlast_i),
      .slv_axis_tready_o (slv_axis_tready_o),
      .mst_axis_tdata_o  (mst_axis_tdata_o),
      .mst_axis_tvalid_o (mst_axis_tvalid_o),
      .mst_axis_tlast_o  (mst_axis_tlast_o),
      .mst_axis_tready_i (mst_axis_tready_i),
      .flush_i           (flush_i),
      .level_o           (level_o),
      .empty_o           (empty_o),
      .full_o            (full_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic int pktCount();
      int n = 0;
      foreach (model_q[i]) begin
         if (model_q[i].tlast) n++;
      end
      return n;
   endfunction

   // A byte may leave when something is stored; in packet mode a complete
   // packet must be present unless the FIFO is full.
   function automatic logic modelValid();
`ifdef UART_TX_FIFO_PKT_MODE_EN
      return (model_q.size() != 0) && ((pktCount() != 0) || (model_q.size() == DEPTH));
`else
      return model_q.size() != 0;
`endif
   endfunction

   task automatic checkAll();
      checkOutput("level",  32'(level_o),           32'(model_q.size()));
      checkOutput("empty",  32'(empty_o),           32'(model_q.size() == 0));
      checkOutput("full",   32'(full_o),            32'(model_q.size() == DEPTH));
      checkOutput("tready", 32'(slv_axis_tready_o), 32'(model_q.size() != DEPTH));
      checkOutput("tvalid", 32'(mst_axis_tvalid_o), 32'(modelValid()));
      if (modelValid()) begin
         checkOutput("tdata", 32'(mst_axis_tdata_o), 32'(model_q[0].tdata));
         checkOutput("tlast", 32'(mst_axis_tlast_o), 32'(model_q[0].tlast));
      end
   endtask

   // Drive one cycle from the falling edge, step the model at the rising
   // edge, then compare everything at the next falling edge.
   task automatic applyStimulus(input logic rst, input logic fl, input logic tv,
                                input logic [DW-1:0] td, input logic tl, input logic tr);
      logic v;
      logic r;
      rst_n_i           = !rst;
      flush_i           = fl;
      slv_axis_tvalid_i = tv;
      slv_axis_tdata_i  = td;
      slv_axis_tlast_i  = tl;
      mst_axis_tready_i = tr;
      v = modelValid();
      r = (model_q.size() != DEPTH);
      @(posedge clk_i);
      if (rst || fl) begin
         model_q.delete();
      end else begin
         if (v && tr) void'(model_q.pop_front());
         if (tv && r) model_q.push_back(uart_entry_t'{tlast: tl, tdata: td});
      end
      @(negedge clk_i);
      checkAll();
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic tr);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, tr);
   endtask

   initial begin
      logic [DW-1:0] seq [3];
      seq[0] = 8'h55;
      seq[1] = 8'hAA;
      seq[2] = 8'h0F;
      @(negedge clk_i);

      doReset();
      checkOutput("rst_level",  32'(level_o),           32'd0);
      checkOutput("rst_empty",  32'(empty_o),           32'd1);
      checkOutput("rst_tready", 32'(slv_axis_tready_o), 32'd1);
      checkOutput("rst_tvalid", 32'(mst_axis_tvalid_o), 32'd0);
      checkOutput("rst_tdata",  32'(mst_axis_tdata_o),  32'd0);
      checkOutput("rst_tlast",  32'(mst_axis_tlast_o),  32'd0);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, seq[i], i == 2, 1'b1);
         checkOutput("seq_tdata", 32'(mst_axis_tdata_o), 32'(seq[i]));
      end
      idle(1'b1);
      checkOutput("seq_level_end", 32'(level_o), 32'd0);

      for (int i = 0; i < DEPTH + 1; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1, 1'b0);
      end
      checkOutput("fill_level",  32'(level_o),           32'(DEPTH));
      checkOutput("fill_full",   32'(full_o),            32'd1);
      checkOutput("fill_tready", 32'(slv_axis_tready_o), 32'd0);
      for (int i = 0; i < DEPTH; i++) idle(1'b1);
      checkOutput("drain_empty", 32'(empty_o), 32'd1);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1, 1'b0);
      end
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1, 1'b1);
      end
      checkOutput("steady_level", 32'(level_o), 32'd8);

      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1);
      checkOutput("flush_level",  32'(level_o),           32'd0);
      checkOutput("flush_tvalid", 32'(mst_axis_tvalid_o), 32'd0);
      idle(1'b1);
      checkOutput("flush_discard", 32'(level_o), 32'd0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1, 1'b0);
      end
      doReset();
      checkOutput("midrst_level",  32'(level_o),           32'd0);
      checkOutput("midrst_empty",  32'(empty_o),           32'd1);
      checkOutput("midrst_tvalid", 32'(mst_axis_tvalid_o), 32'd0);
      checkOutput("midrst_tready", 32'(slv_axis_tready_o), 32'd1);

`ifdef UART_TX_FIFO_PKT_MODE_EN
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
      checkOutput("pkt_hold", 32'(mst_axis_tvalid_o), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0);
      checkOutput("pkt_release", 32'(mst_axis_tvalid_o), 32'd1);
      checkOutput("pkt_first",   32'(mst_axis_tdata_o),  32'h01);
      idle(1'b1);
      idle(1'b1);
      checkOutput("pkt_third", 32'(mst_axis_tdata_o), 32'h03);
      checkOutput("pkt_tlast", 32'(mst_axis_tlast_o), 32'd1);
      idle(1'b1);
      doReset();
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0, 1'b1);
      end
      checkOutput("pkt_full_release", 32'(mst_axis_tvalid_o), 32'd1);
      for (int i = 0; i < DEPTH; i++) idle(1'b1);
`endif

      doReset();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'b0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                       DW'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
      end
      for (int i = 0; i < 3 * DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, $urandom_range(0, 1) == 0, DW'($urandom), 1'b1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
